// File: rtl/ex_operand_muldiv.sv
// EX-stage operand forwarding muxes plus an iterative HI/LO multiply/divide unit.
// One product or quotient bit per cycle; the unit stalls only instructions that need it.
module ex_operand_muldiv #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [1:0]       forward1,
    input  logic [1:0]       forward2,
    input  logic [WIDTH-1:0] alu_result_EX_MEM,
    input  logic [WIDTH-1:0] wb_data_MEM_WB,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mf_req,
    input  logic             flush,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_busy,
    output logic             md_done,
    output logic             stall
);

    localparam logic [1:0] SEL_FORWARD_RAW = 2'b00;
    localparam logic [1:0] SEL_FORWARD_EX  = 2'b10;
    localparam logic [1:0] SEL_FORWARD_MEM = 2'b01;
    localparam int         CW              = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] raw,
                                                 input logic [WIDTH-1:0] ex,
                                                 input logic [WIDTH-1:0] mem);
        case (sel)
            SEL_FORWARD_RAW: fwd_mux = raw;
            SEL_FORWARD_EX:  fwd_mux = ex;
            SEL_FORWARD_MEM: fwd_mux = mem;
            default:         fwd_mux = raw;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        cond_neg = neg ? (~v + WIDTH'(1)) : v;
    endfunction

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               divz_q, divz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     msum, dshift, dtrial;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign opA     = fwd_mux(forward1, rs_data, alu_result_EX_MEM, wb_data_MEM_WB);
    assign opB     = fwd_mux(forward2, rt_data, alu_result_EX_MEM, wb_data_MEM_WB);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign md_done = done_q;
    assign md_busy = (state_q != S_IDLE);
    assign stall   = md_busy & (md_start | mf_req | mthi | mtlo);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        op_d      = op_q;
        raw_a_d   = raw_a_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        divz_d    = divz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        is_signed = ~md_op[0];
        abs_a     = cond_neg(is_signed & opA[WIDTH-1], opA);
        abs_b     = cond_neg(is_signed & opB[WIDTH-1], opB);
        // Shift-add step: add multiplicand into the upper half when the low bit is set.
        msum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_q} : '0);
        // Restoring step: bring in the next dividend bit and try the subtraction.
        dshift    = {acc_hi_q, acc_lo_q[WIDTH-1]};
        dtrial    = dshift - {1'b0, op_q};
        prod      = {acc_hi_q, acc_lo_q};
        prod_fix  = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md_start) begin
                        cnt_d    = '0;
                        acc_hi_d = '0;
                        neg_d    = is_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        rneg_d   = is_signed & opA[WIDTH-1];
                        raw_a_d  = opA;
                        divz_d   = md_op[1] & (opB == '0);
                        if (md_op[1]) begin
                            state_d  = S_DIV;
                            op_d     = abs_b;
                            acc_lo_d = abs_a;
                        end else begin
                            state_d  = S_MUL;
                            op_d     = abs_a;
                            acc_lo_d = abs_b;
                        end
                    end else begin
                        if (mthi) hi_d = opA;
                        if (mtlo) lo_d = opA;
                    end
                end
                S_MUL: begin
                    if (cnt_q == CW'(ITER)) begin
                        hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d    = prod_fix[WIDTH-1:0];
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        acc_hi_d = msum[WIDTH:1];
                        acc_lo_d = {msum[0], acc_lo_q[WIDTH-1:1]};
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
                S_DIV: begin
                    if (cnt_q == CW'(ITER)) begin
                        if (divz_q) begin
                            lo_d = '1;
                            hi_d = raw_a_q;
                        end else begin
                            lo_d = cond_neg(neg_q, acc_lo_q);
                            hi_d = cond_neg(rneg_q, acc_hi_q);
                        end
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        if (dshift >= {1'b0, op_q}) begin
                            acc_hi_d = dtrial[WIDTH-1:0];
                            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_d = dshift[WIDTH-1:0];
                            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                        end
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            op_q     <= '0;
            raw_a_q  <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            op_q     <= op_d;
            raw_a_q  <= raw_a_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            divz_q   <= divz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: doc/ex_operand_muldiv.md
Name: ex_operand_muldiv

Overview:
- EX-stage block that consumes the forwarding unit's rs/rt select codes.
- Its operand muxes pick the register-file value, the EX/MEM ALU result, or the MEM/WB write-back value, and present them to the ALU.
- It also contains the iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- It raises a pipeline stall while an operation is in flight.

Parameters:
- WIDTH, 32, datapath width; HI/LO are WIDTH each and the product is 2*WIDTH.
- ITER, 32, iteration cycles per mul/div; must equal WIDTH.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- rs_data  input  WIDTH  rs value from ID/EX register
- rt_data  input  WIDTH  rt value from ID/EX register
- forward1  input  2  rs select from forwarding unit
- forward2  input  2  rt select from forwarding unit
- alu_result_EX_MEM  input  WIDTH  forwarded EX/MEM ALU result
- wb_data_MEM_WB  input  WIDTH  forwarded MEM/WB write-back data
- md_start  input  1  EX holds a mul/div instruction this cycle
- md_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- mthi  input  1  write opA to HI
- mtlo  input  1  write opA to LO
- mf_req  input  1  EX holds MFHI/MFLO
- flush  input  1  abort in-flight op (exception/branch flush)
- opA  output  WIDTH  forwarded rs operand (combinational)
- opB  output  WIDTH  forwarded rt operand (combinational)
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- md_busy  output  1  operation in flight
- md_done  output  1  one-cycle pulse when HI/LO committed
- stall  output  1  hold IF/ID/EX stages

Behaviour:
- Operand mux, purely combinational:
  - `SEL_FORWARD_RAW (2'b00) -> rs_data/rt_data.
  - `SEL_FORWARD_EX (2'b10) -> alu_result_EX_MEM.
  - `SEL_FORWARD_MEM (2'b01) -> wb_data_MEM_WB.
  - 2'b11 -> raw register value.
  - Mul/div and MTHI/MTLO use opA/opB, never raw data.
- Reset (async):
  - state=IDLE; hi=lo=0; md_busy=0; md_done=0; iteration counter=0; internal accumulators=0.
- States: IDLE, MUL, DIV.
- IDLE with md_start=1 at edge T:
  - Latch |opA| and |opB| (signed ops) or raw opA/opB (unsigned ops).
  - Latch the sign of the result/remainder.
  - Enter MUL or DIV with count=0.
- MUL: radix-2 shift-add, one bit per edge.
- DIV: restoring division, one quotient bit per edge.
- Completion:
  - After ITER iteration edges (edges T+1..T+32), the edge T+33 applies the sign fix and writes HI/LO.
  - MUL: HI = product[63:32], LO = product[31:0].
  - DIV: LO = quotient, HI = remainder; remainder takes the sign of the dividend.
  - State returns to IDLE and md_done=1 for exactly the following cycle.
- md_busy=1 while state != IDLE (33 cycles per op).
- stall = md_busy & (md_start | mf_req | mthi | mtlo).
  - Unrelated instructions proceed while the unit runs.
  - stall is 0 in the md_done cycle.
  - A new md_start may be accepted in the md_done cycle.
- md_start, mthi and mtlo while busy: ignored by the unit (the pipeline is stalled and reissues them).
- mthi/mtlo in IDLE: HI or LO <= opA at the next edge.
  - Both asserted in the same cycle: both written.
  - mthi/mtlo asserted together with md_start: md_start wins and mthi/mtlo are ignored.
- Divide by zero (opB==0, DIV/DIVU):
  - Still takes the full 33 cycles.
  - Result LO = all ones, HI = dividend (opA as latched, before abs).
- Signed overflow, DIV 0x80000000 / -1: LO=0x80000000, HI=0.
- flush:
  - In any state at the next edge: state=IDLE, counter=0, no md_done, HI/LO unchanged.
  - flush has priority over md_start in the same cycle.
- rst mid-operation: immediate return to reset values; no md_done.

Test Plan:
- forward1=2'b10, forward2=2'b01, rs_data=1, rt_data=2, alu_result=0xAAAA0000, wb_data=0x5555 -> opA=0xAAAA0000, opB=0x5555; forward codes 00 and 11 -> opA=1, opB=2.
- MULT opA=0xFFFFFFFD (-3), opB=5 -> md_busy for 33 cycles, md_done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV 9/0 -> 33 busy cycles, LO=0xFFFFFFFF, HI=9.
- MULT in flight with mf_req asserted at cycle 5 -> stall=1 until the md_done cycle, stall=0 there; with md_start held high, back-to-back op accepted in the md_done cycle.
- HI=LO=0x1234 preloaded via mthi/mtlo, then MULT started and flush at cycle 10 -> state IDLE next cycle, no md_done, HI=LO=0x1234; rst at cycle 20 of a DIV -> all outputs 0 immediately.
